// File: rtl/usb_tx_sched_if.sv
// Bundle between the two requesters, the scheduler and the USB transmit pipeline.
// Handshake: req_valid[i] is a level held until the one-cycle req_ack[i] pulse; req_done[i]/req_err close it.
interface usb_tx_sched_if;
  logic [1:0]  req_valid;
  logic [3:0]  req0_pid;
  logic [3:0]  req1_pid;
  logic [3:0]  req0_endp;
  logic [3:0]  req1_endp;
  logic [6:0]  req0_addr;
  logic [6:0]  req1_addr;
  logic [63:0] req0_data;
  logic [63:0] req1_data;
  logic [1:0]  req_ack;
  logic [1:0]  req_done;
  logic        req_err;
  logic [3:0]  pid;
  logic [3:0]  endp;
  logic [6:0]  addr;
  logic [63:0] data;
  logic        pktready_bs;
  logic        gotpkt_bs;
  logic        tx_busy;
  logic        sched_idle;
  logic [1:0]  dbg_state;

  modport slave (
    input  req_valid, req0_pid, req1_pid, req0_endp, req1_endp,
           req0_addr, req1_addr, req0_data, req1_data, gotpkt_bs, tx_busy,
    output req_ack, req_done, req_err, pid, endp, addr, data,
           pktready_bs, sched_idle, dbg_state
  );

  modport master (
    output req_valid, req0_pid, req1_pid, req0_endp, req1_endp,
           req0_addr, req1_addr, req0_data, req1_data, gotpkt_bs, tx_busy,
    input  req_ack, req_done, req_err, pid, endp, addr, data,
           pktready_bs, sched_idle, dbg_state
  );
endinterface

// File: rtl/usb_tx_sched.sv
// Round-robin transmit scheduler: grants one of two requesters, runs the pktready/gotpkt
// handshake, waits for the wire to drain, enforces an inter-packet gap and reports status.
module usb_tx_sched #(
  parameter int IPG         = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int PKT_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  usb_tx_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_GAP} state_t;

  localparam int AW = $clog2(ACK_TIMEOUT + 2);
  localparam int PW = $clog2(PKT_TIMEOUT + 2);
  localparam int GW = $clog2(IPG + 2);
  localparam logic [AW-1:0] ACK_LIM = AW'(ACK_TIMEOUT);
  localparam logic [PW-1:0] PKT_LIM = PW'(PKT_TIMEOUT);
  localparam logic [GW-1:0] GAP_LIM = GW'(IPG);

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [AW-1:0] ack_cnt_q, ack_cnt_d, ack_inc;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d, pkt_inc;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d, gap_inc;
  logic          seen_busy_q, seen_busy_d;
  logic [1:0]    req_ack_q, req_ack_d;
  logic [1:0]    req_done_q, req_done_d;
  logic          req_err_q, req_err_d;
  logic          pktready_q, pktready_d;
  logic [3:0]    pid_q, pid_d;
  logic [3:0]    endp_q, endp_d;
  logic [6:0]    addr_q, addr_d;
  logic [63:0]   data_q, data_d;
  logic          sched_idle_q, sched_idle_d;
  logic          win;
  logic [1:0]    done_vec;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ack_cnt_d    = ack_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    seen_busy_d  = seen_busy_q;
    req_ack_d    = 2'b00;
    req_done_d   = 2'b00;
    req_err_d    = 1'b0;
    pktready_d   = pktready_q;
    pid_d        = pid_q;
    endp_d       = endp_q;
    addr_d       = addr_q;
    data_d       = data_q;

    // Tie goes to the requester not served last; a lone requester always wins.
    win      = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
    done_vec = last_grant_q ? 2'b10 : 2'b01;
    ack_inc  = (&ack_cnt_q) ? ack_cnt_q : ack_cnt_q + 1'b1;
    pkt_inc  = (&pkt_cnt_q) ? pkt_cnt_q : pkt_cnt_q + 1'b1;
    gap_inc  = (&gap_cnt_q) ? gap_cnt_q : gap_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid != 2'b00 && !bus.tx_busy) begin
          state_d      = S_SEND;
          last_grant_d = win;
          req_ack_d    = win ? 2'b10 : 2'b01;
          pktready_d   = 1'b1;
          ack_cnt_d    = '0;
          pid_d        = win ? bus.req1_pid  : bus.req0_pid;
          endp_d       = win ? bus.req1_endp : bus.req0_endp;
          addr_d       = win ? bus.req1_addr : bus.req0_addr;
          data_d       = win ? bus.req1_data : bus.req0_data;
        end
      end
      S_SEND: begin
        // An accept in the same cycle as the timeout still counts as success.
        if (bus.gotpkt_bs) begin
          pktready_d = 1'b0;
          state_d    = S_DRAIN;
        end else if (ack_inc >= ACK_LIM) begin
          pktready_d = 1'b0;
          req_done_d = done_vec;
          req_err_d  = 1'b1;
          state_d    = S_GAP;
          ack_cnt_d  = '0;
          pkt_cnt_d  = '0;
          gap_cnt_d  = '0;
          seen_busy_d = 1'b0;
        end else begin
          ack_cnt_d = ack_inc;
        end
      end
      S_DRAIN: begin
        seen_busy_d = seen_busy_q | bus.tx_busy;
        if (seen_busy_q && !bus.tx_busy) begin
          req_done_d  = done_vec;
          state_d     = S_GAP;
          ack_cnt_d   = '0;
          pkt_cnt_d   = '0;
          gap_cnt_d   = '0;
          seen_busy_d = 1'b0;
        end else if (pkt_inc >= PKT_LIM) begin
          req_done_d  = done_vec;
          req_err_d   = 1'b1;
          state_d     = S_GAP;
          ack_cnt_d   = '0;
          pkt_cnt_d   = '0;
          gap_cnt_d   = '0;
          seen_busy_d = 1'b0;
        end else begin
          pkt_cnt_d = pkt_inc;
        end
      end
      S_GAP: begin
        if (gap_inc >= GAP_LIM) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    sched_idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      ack_cnt_q    <= '0;
      pkt_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      seen_busy_q  <= 1'b0;
      req_ack_q    <= 2'b00;
      req_done_q   <= 2'b00;
      req_err_q    <= 1'b0;
      pktready_q   <= 1'b0;
      pid_q        <= '0;
      endp_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      sched_idle_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ack_cnt_q    <= ack_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      seen_busy_q  <= seen_busy_d;
      req_ack_q    <= req_ack_d;
      req_done_q   <= req_done_d;
      req_err_q    <= req_err_d;
      pktready_q   <= pktready_d;
      pid_q        <= pid_d;
      endp_q       <= endp_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      sched_idle_q <= sched_idle_d;
    end
  end

  assign bus.req_ack     = req_ack_q;
  assign bus.req_done    = req_done_q;
  assign bus.req_err     = req_err_q;
  assign bus.pid         = pid_q;
  assign bus.endp        = endp_q;
  assign bus.addr        = addr_q;
  assign bus.data        = data_q;
  assign bus.pktready_bs = pktready_q;
  assign bus.sched_idle  = sched_idle_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed bench for usb_tx_sched: ack/done events and granted fields are predicted into
// queues when stimulus is applied and popped as the scheduler emits them.
module tb_usb_tx_sched;
  localparam int IPG    = 4;
  localparam int ACK_TO = 16;
  localparam int PKT_TO = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_tx_sched_if bus();

  usb_tx_sched #(.IPG(IPG), .ACK_TIMEOUT(ACK_TO), .PKT_TIMEOUT(PKT_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Event word: {is_done, err, onehot requester}
  logic [3:0]  exp_q[$];
  logic [78:0] fld_q[$];
  int          last_ack_cyc, last_done_cyc;
  bit          ack_seen, done_seen;
  logic        mdl_lg;
  logic [78:0] fld0, fld1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0]  ev, e;
    logic [78:0] f;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.req_ack != 2'b00 || bus.req_done != 2'b00) begin
      ev = {bus.req_done != 2'b00, bus.req_err, bus.req_ack | bus.req_done};
      if (bus.req_ack != 2'b00) begin
        ack_seen = 1'b1;
        last_ack_cyc = cyc;
      end
      if (bus.req_done != 2'b00) begin
        done_seen = 1'b1;
        last_done_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 128'(ev), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("event", 128'(ev), 128'(e));
      end
      if (bus.req_ack != 2'b00) begin
        if (fld_q.size() == 0) begin
          chk("unexpected_grant", 128'(bus.req_ack), 128'(0));
        end else begin
          f = fld_q.pop_front();
          chk("grant_fields", 128'({bus.pid, bus.endp, bus.addr, bus.data}), 128'(f));
        end
      end
    end
  endtask

  task automatic set_fields();
    {bus.req0_pid, bus.req0_endp, bus.req0_addr, bus.req0_data} = fld0;
    {bus.req1_pid, bus.req1_endp, bus.req1_addr, bus.req1_data} = fld1;
  endtask

  task automatic push_pkt(input logic w, input logic err_exp, input bit with_done);
    exp_q.push_back({1'b0, 1'b0, w ? 2'b10 : 2'b01});
    fld_q.push_back(w ? fld1 : fld0);
    if (with_done) exp_q.push_back({1'b1, err_exp, w ? 2'b10 : 2'b01});
  endtask

  task automatic wait_ack(input string tag);
    ack_seen = 1'b0;
    for (int i = 0; i < 64 && !ack_seen; i++) tick();
    chk(tag, 128'(ack_seen), 128'(1));
  endtask

  task automatic wait_done(input string tag, input int bound);
    done_seen = 1'b0;
    for (int i = 0; i < bound && !done_seen; i++) tick();
    chk(tag, 128'(done_seen), 128'(1));
  endtask

  // Called just after an ack: accept after got_dly cycles, then busy for busy_len cycles.
  task automatic serve_ok(input int got_dly, input int busy_len);
    int t;
    for (int i = 0; i < got_dly; i++) begin
      tick();
      chk("pktready_hold", 128'(bus.pktready_bs), 128'(1));
    end
    bus.gotpkt_bs = 1'b1;
    tick();
    bus.gotpkt_bs = 1'b0;
    chk("pktready_drop", 128'(bus.pktready_bs), 128'(0));
    bus.tx_busy = 1'b1;
    for (int i = 0; i < busy_len; i++) tick();
    bus.tx_busy = 1'b0;
    t = cyc;
    wait_done("done_wait", 8);
    chk("done_latency", 128'(last_done_cyc - t), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic w, other;
    int   hi, s, t;

    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.gotpkt_bs = 1'b0;
    bus.tx_busy   = 1'b0;
    fld0 = {4'b0001, 4'h2, 7'h05, {$urandom, $urandom}};
    fld1 = {4'hA, 4'h7, 7'h33, 64'hDEADBEEF_01234567};
    set_fields();
    mdl_lg = 1'b1;
    repeat (3) tick();

    // Reset values
    chk("rst_ack", 128'(bus.req_ack), 128'(0));
    chk("rst_done", 128'({bus.req_done, bus.req_err}), 128'(0));
    chk("rst_pktready", 128'(bus.pktready_bs), 128'(0));
    chk("rst_fields", 128'({bus.pid, bus.endp, bus.addr, bus.data}), 128'(0));
    chk("rst_idle", 128'(bus.sched_idle), 128'(1));
    rst = 1'b0;
    tick();

    // Single request on req0
    bus.req_valid = 2'b01;
    push_pkt(1'b0, 1'b0, 1'b1);
    t = cyc;
    wait_ack("single_ack");
    chk("ack_latency", 128'(last_ack_cyc - t), 128'(1));
    mdl_lg = 1'b0;
    bus.req_valid = 2'b00;
    chk("single_pktready", 128'(bus.pktready_bs), 128'(1));
    chk("single_not_idle", 128'(bus.sched_idle), 128'(0));
    serve_ok(2, 20);

    // Contention: both held, grants alternate; first one also measures the gap
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = ~mdl_lg;
      push_pkt(w, 1'b0, 1'b1);
      wait_ack("cont_ack");
      if (k == 0) chk("ipg_gap", 128'(last_ack_cyc - last_done_cyc), 128'(IPG + 1));
      mdl_lg = w;
      tick();
      chk("cont_data_hold", 128'(bus.data), 128'(w ? fld1[63:0] : fld0[63:0]));
      serve_ok(1, 5);
      if (k == 3) bus.req_valid = 2'b00;
    end

    // ACK timeout, then the other pending requester after the gap
    repeat (6) tick();
    fld0 = {4'h9, 4'h3, 7'h11, {$urandom, $urandom}};
    set_fields();
    bus.req_valid = 2'b11;
    w = ~mdl_lg;
    other = ~w;
    push_pkt(w, 1'b1, 1'b1);
    push_pkt(other, 1'b0, 1'b1);
    wait_ack("to_ack");
    mdl_lg = w;
    bus.req_valid = other ? 2'b10 : 2'b01;
    hi = 0;
    done_seen = 1'b0;
    while (bus.pktready_bs === 1'b1 && hi < 40) begin
      hi++;
      tick();
    end
    chk("ack_to_len", 128'(hi), 128'(ACK_TO));
    chk("ack_to_done_seen", 128'(done_seen), 128'(1));
    chk("ack_to_done_cycle", 128'(last_done_cyc), 128'(cyc));
    wait_ack("after_to_ack");
    chk("after_to_gap", 128'(last_ack_cyc - last_done_cyc), 128'(IPG + 1));
    mdl_lg = other;
    bus.req_valid = 2'b00;
    serve_ok(0, 3);

    // Drain timeout: accepted but the wire never goes busy
    repeat (6) tick();
    bus.req_valid = 2'b01;
    push_pkt(1'b0, 1'b1, 1'b1);
    wait_ack("drain_ack");
    mdl_lg = 1'b0;
    bus.req_valid = 2'b00;
    tick();
    bus.gotpkt_bs = 1'b1;
    tick();
    bus.gotpkt_bs = 1'b0;
    s = cyc;
    wait_done("drain_to_wait", PKT_TO + 50);
    chk("drain_to_cycles", 128'(last_done_cyc - s), 128'(PKT_TO));

    // Busy gating in IDLE
    repeat (6) tick();
    bus.tx_busy = 1'b1;
    bus.req_valid = 2'b01;
    push_pkt(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_gate_no_ack", 128'(bus.req_ack), 128'(0));
    end
    bus.tx_busy = 1'b0;
    t = cyc;
    wait_ack("busy_gate_ack");
    chk("busy_gate_latency", 128'(last_ack_cyc - t), 128'(1));
    mdl_lg = 1'b0;
    bus.req_valid = 2'b00;

    // Reset in the middle of DRAIN
    tick();
    bus.gotpkt_bs = 1'b1;
    tick();
    bus.gotpkt_bs = 1'b0;
    bus.tx_busy = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_ack_done", 128'({bus.req_ack, bus.req_done, bus.req_err}), 128'(0));
    chk("mid_rst_pktready", 128'(bus.pktready_bs), 128'(0));
    chk("mid_rst_fields", 128'({bus.pid, bus.endp, bus.addr, bus.data}), 128'(0));
    chk("mid_rst_idle", 128'(bus.sched_idle), 128'(1));
    mdl_lg = 1'b1;
    rst = 1'b0;
    bus.tx_busy = 1'b0;
    repeat (3) tick();
    bus.req_valid = 2'b11;
    w = ~mdl_lg;
    push_pkt(w, 1'b0, 1'b1);
    wait_ack("post_rst_ack");
    mdl_lg = w;
    bus.req_valid = 2'b00;
    serve_ok(1, 4);

    repeat (8) tick();
    chk("events_drained", 128'(exp_q.size()), 128'(0));
    chk("fields_drained", 128'(fld_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
